timer: RTL

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/timer.sv
// Memory-mapped timer: prescaled up-counter with compare match, optional auto-reload
// and a level interrupt. Four word registers: CTRL, COUNT, COMPARE, PRESCALE.
module timer #(
  parameter int unsigned     DW      = 32,
  parameter int unsigned     AW      = 32,
  parameter logic [AW-1:0]   BASE    = 32'h0000_0100,
  parameter int unsigned     INT_W   = 8,
  parameter int unsigned     IRQ_BIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_wd,
  input  logic             mem_ctrl,
  output logic [DW-1:0]    mem_rd,
  output logic             hit,
  // "int" is a reserved word, hence the prefixed name
  output logic [INT_W-1:0] o_int
);

  localparam logic [1:0] RegCtrl     = 2'd0;
  localparam logic [1:0] RegCount    = 2'd1;
  localparam logic [1:0] RegCompare  = 2'd2;
  localparam logic [1:0] RegPrescale = 2'd3;

  logic          r_en, r_ie, r_pend, r_ar;
  logic [DW-1:0] r_count, r_compare, r_prescale, r_psc;

  logic          w_en_d, w_ie_d, w_pend_d, w_ar_d;
  logic [DW-1:0] w_count_d, w_compare_d, w_prescale_d, w_psc_d;
  logic          w_we, w_tick, w_match;
  logic [1:0]    w_sel;

  assign hit     = (mem_addr[AW-1:2] == BASE[AW-1:2]);
  assign w_sel   = mem_addr[1:0];
  assign w_we    = hit & mem_ctrl;
  assign w_tick  = r_en & (r_psc == r_prescale);
  assign w_match = w_tick & (r_count == r_compare);

  always_comb begin
    w_en_d       = r_en;
    w_ie_d       = r_ie;
    w_ar_d       = r_ar;
    w_pend_d     = r_pend;
    w_count_d    = r_count;
    w_compare_d  = r_compare;
    w_prescale_d = r_prescale;
    w_psc_d      = r_psc;

    if (!r_en || w_tick) begin
      w_psc_d = '0;
    end else begin
      w_psc_d = r_psc + DW'(1);
    end

    if (w_tick) begin
      w_count_d = (w_match && r_ar) ? '0 : r_count + DW'(1);
    end

    // Clear is applied first so a coincident match-set overrides it
    if (w_we && (w_sel == RegCtrl) && mem_wd[2]) begin
      w_pend_d = 1'b0;
    end
    if (w_match) begin
      w_pend_d = 1'b1;
    end

    if (w_we) begin
      unique case (w_sel)
        RegCtrl: begin
          w_en_d = mem_wd[0];
          w_ie_d = mem_wd[1];
          w_ar_d = mem_wd[3];
        end
        RegCount:   w_count_d   = mem_wd;
        RegCompare: w_compare_d = mem_wd;
        RegPrescale: begin
          w_prescale_d = mem_wd;
          w_psc_d      = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_pend     <= 1'b0;
      r_ar       <= 1'b0;
      r_count    <= '0;
      r_compare  <= '1;
      r_prescale <= '0;
      r_psc      <= '0;
    end else begin
      r_en       <= w_en_d;
      r_ie       <= w_ie_d;
      r_pend     <= w_pend_d;
      r_ar       <= w_ar_d;
      r_count    <= w_count_d;
      r_compare  <= w_compare_d;
      r_prescale <= w_prescale_d;
      r_psc      <= w_psc_d;
    end
  end

  always_comb begin
    mem_rd = '0;
    if (hit) begin
      unique case (w_sel)
        RegCtrl:     mem_rd = {{(DW-4){1'b0}}, r_ar, r_pend, r_ie, r_en};
        RegCount:    mem_rd = r_count;
        RegCompare:  mem_rd = r_compare;
        RegPrescale: mem_rd = r_prescale;
        default:     mem_rd = '0;
      endcase
    end
  end

  always_comb begin
    o_int          = '0;
    o_int[IRQ_BIT] = r_pend & r_ie;
  end

endmodule
